// File: rtl/an_frame_encoder_n13_pkg.sv
// Shared constants and types for the AN-code frame encoder.
package an_frame_encoder_n13_pkg;

    // AN-code multiplier and field widths
    localparam int AN_A    = 13;
    localparam int MSG_W   = 3;
    localparam int CW_W    = 6;

    // Frame geometry: slots are numbered row-major, k = row*N_COLS + col
    localparam int N_ROWS  = 5;
    localparam int N_COLS  = 5;
    localparam int N_SLOTS = N_ROWS * N_COLS;
    localparam int CNT_W   = $clog2(N_SLOTS);

    // Largest message value that is a valid AN-code input
    localparam int MSG_MAX = 4;

    // FILL collects messages; HOLD presents a finished frame downstream
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/an_frame_encoder_n13_if.sv
// Message-in / frame-out handshake bundle of the AN-code frame encoder.
interface an_frame_encoder_n13_if;
    import an_frame_encoder_n13_pkg::*;

    logic                       msg_valid;
    logic [MSG_W-1:0]           msg;
    logic                       msg_ready;
    logic                       flush;
    logic                       frame_valid;
    logic                       frame_ready;
    logic [N_SLOTS*CW_W-1:0]    cw_flat;
    logic                       range_err;

    // Encoder side: consumes messages, produces frames
    modport slave (
        input  msg_valid, msg, flush, frame_ready,
        output msg_ready, frame_valid, cw_flat, range_err
    );

    // Environment side: produces messages, consumes frames
    modport master (
        output msg_valid, msg, flush, frame_ready,
        input  msg_ready, frame_valid, cw_flat, range_err
    );

endinterface

// File: rtl/an_encoder_n13.sv
// Combinational AN-code encoder: codeword = AN_A * msg, truncated to CW_W bits.
module an_encoder_n13 #(
    parameter int AN_A  = an_frame_encoder_n13_pkg::AN_A,
    parameter int MSG_W = an_frame_encoder_n13_pkg::MSG_W,
    parameter int CW_W  = an_frame_encoder_n13_pkg::CW_W
) (
    input  logic [MSG_W-1:0] i_msg,
    output logic [CW_W-1:0]  o_cw
);

    logic [CW_W-1:0] w_acc;

    // Shift-and-add over the set bits of AN_A; for 13 this is (m<<3)+(m<<2)+m.
    // Shifts at or above CW_W vanish under truncation, so only low bits are scanned.
    always_comb begin
        // NOTE: blocking '=' is required here so each loop iteration sees the
        // running sum from the previous one; the default assignment first keeps
        // the block free of latches.
        w_acc = '0;
        for (int i = 0; i < CW_W; i++) begin
            if (((AN_A >> i) & 1) == 1) begin
                w_acc = w_acc + (CW_W'(i_msg) << i);
            end
        end
    end

    assign o_cw = w_acc;

endmodule

// File: rtl/an_frame_encoder_n13.sv
// AN-code frame encoder: packs 25 encoded messages row-major into one frame,
// presents it with a valid/ready handshake and flags out-of-range messages.
module an_frame_encoder_n13 #(
    parameter int AN_A   = an_frame_encoder_n13_pkg::AN_A,
    parameter int MSG_W  = an_frame_encoder_n13_pkg::MSG_W,
    parameter int CW_W   = an_frame_encoder_n13_pkg::CW_W,
    parameter int N_ROWS = an_frame_encoder_n13_pkg::N_ROWS,
    parameter int N_COLS = an_frame_encoder_n13_pkg::N_COLS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    an_frame_encoder_n13_if.slave   bus
);
    import an_frame_encoder_n13_pkg::MSG_MAX;
    import an_frame_encoder_n13_pkg::state_t;
    import an_frame_encoder_n13_pkg::ST_FILL;
    import an_frame_encoder_n13_pkg::ST_HOLD;

    localparam int N_SL  = N_ROWS * N_COLS;
    localparam int CNT_W = $clog2(N_SL);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_alive;
    logic [CNT_W-1:0]       r_cnt;
    logic [CW_W-1:0]        r_slot [N_SL];
    logic                   r_range_err;

    logic [MSG_W-1:0]       w_msg;
    logic [CW_W-1:0]        w_cw;
    logic                   w_oor;
    logic                   w_msg_ready;
    logic                   w_frame_valid;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_close;
    logic                   w_handshake;
    logic [N_SL*CW_W-1:0]   w_flat;

    assign w_msg = bus.msg;

    an_encoder_n13 #(
        .AN_A  (AN_A),
        .MSG_W (MSG_W),
        .CW_W  (CW_W)
    ) u_enc (
        .i_msg (w_msg),
        .o_cw  (w_cw)
    );

    assign w_oor       = (w_msg > MSG_W'(MSG_MAX));
    assign w_accept    = bus.msg_valid & w_msg_ready;
    assign w_last      = w_accept && (r_cnt == CNT_W'(N_SL - 1));
    // A flush closes the frame only if it would hold at least one message
    assign w_close     = (r_state == ST_FILL) && bus.flush && (w_accept || (r_cnt != '0));
    assign w_handshake = w_frame_valid & bus.frame_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: close on the 25th message or a flush, reopen on handshake
    always_comb begin
        // NOTE: default to the current state so every path assigns w_next_state
        // and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_FILL: if (w_last || w_close) w_next_state = ST_HOLD;
            ST_HOLD: if (w_handshake)       w_next_state = ST_FILL;
            default: w_next_state = ST_FILL;
        endcase
    end

    // Output decode from registered state only; msg never reaches these
    always_comb begin
        w_msg_ready   = 1'b0;
        w_frame_valid = 1'b0;
        case (r_state)
            ST_FILL: w_msg_ready   = r_alive;
            ST_HOLD: w_frame_valid = 1'b1;
            default: ;
        endcase
    end

    // Holds msg_ready low during reset and releases it at the first clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Slot pointer: advances per accepted message, returns to 0 when a frame closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_handshake || w_last || w_close) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Frame buffer: write the accepted codeword into slot r_cnt, clear on handshake.
    // Slots are all zero whenever a frame starts, so flush padding comes for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is reset explicitly because cw_flat must read zero
            // during reset and unwritten slots must read zero after a flush.
            for (int k = 0; k < N_SL; k++) begin
                r_slot[k] <= '0;
            end
        end else if (w_handshake) begin
            for (int k = 0; k < N_SL; k++) begin
                r_slot[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < N_SL; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_slot[k] <= w_cw;
                end
            end
        end
    end

    // Sticky range flag for the frame being built or presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_handshake) begin
            r_range_err <= 1'b0;
        end else if (w_accept && w_oor) begin
            r_range_err <= 1'b1;
        end
    end

    // Flatten slots: slot k occupies bits [CW_W*k +: CW_W]
    always_comb begin
        w_flat = '0;
        for (int k = 0; k < N_SL; k++) begin
            w_flat[k*CW_W +: CW_W] = r_slot[k];
        end
    end

    assign bus.msg_ready   = w_msg_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.cw_flat     = w_flat;
    assign bus.range_err   = r_range_err;

endmodule

// File: doc/an_frame_encoder_n13.md
AN_FRAME_ENCODER_N13 -- requirements
Module: an_frame_encoder_n13

Interface
REQ-001 Parameter AN_A, default 13, AN-code multiplier.
REQ-002 Parameter MSG_W, default 3, message width in bits.
REQ-003 Parameter CW_W, default 6, codeword width in bits.
REQ-004 Parameter N_ROWS, default 5, frame rows; N_COLS, default 5, frame columns; frame holds 25 slots.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 msg_valid  input  1  upstream message valid.
REQ-008 msg  input  MSG_W  message to encode.
REQ-009 msg_ready  output  1  encoder can accept a message.
REQ-010 flush  input  1  pad the rest of the current frame with zero codewords and close it.
REQ-011 frame_valid  output  1  complete frame presented on cw_flat.
REQ-012 frame_ready  input  1  downstream accepts the frame.
REQ-013 cw_flat  output  N_ROWS*N_COLS*CW_W (150)  slot k = row*5+col occupies bits [6k+5:6k].
REQ-014 range_err  output  1  at least one message in the presented frame exceeded 4.

Function
REQ-015 Codeword SHALL be AN_A*msg, computed as (msg<<3)+(msg<<2)+msg and truncated to CW_W bits.
REQ-016 Messages 0..4 SHALL be in range. Messages 5..7 SHALL be encoded per REQ-015 (truncated) and SHALL set the frame's range_err flag.
REQ-017 FSM states: FILL and HOLD. Reset state is FILL.
REQ-018 In FILL, msg_ready SHALL be 1. In HOLD, msg_ready SHALL be 0.
REQ-019 A message is accepted when msg_valid and msg_ready are both 1.
REQ-020 Each accepted message SHALL be written to slot cnt, and the 5-bit cnt SHALL increment by 1.
REQ-021 Slots SHALL fill in row-major order, 0 to 24.
REQ-022 When slot 24 is accepted, the FSM SHALL go to HOLD and cnt SHALL wrap to 0.
REQ-023 frame_valid SHALL be 1 exactly while in HOLD; it rises the cycle after the 25th acceptance (latency 1).
REQ-024 In HOLD, cw_flat and range_err SHALL be stable until the handshake.
REQ-025 Handshake: frame_valid and frame_ready both 1 -> buffer cleared to 0, range_err cleared, cnt = 0, return to FILL next cycle.
REQ-026 frame_ready while in FILL SHALL have no effect.
REQ-027 flush in FILL with cnt>0: all slots not yet written SHALL read as 0, and the FSM SHALL go to HOLD next cycle.
REQ-028 flush in FILL with cnt=0 and no accepted message SHALL be ignored.
REQ-029 flush together with an acceptance: the message is stored in slot cnt, the remaining slots are zero-padded, and the FSM goes to HOLD.
REQ-030 flush in HOLD SHALL be ignored.
REQ-031 The 25th acceptance together with flush SHALL behave as a normal frame completion.
REQ-032 Outputs SHALL be registered; no combinational path from msg to cw_flat or frame_valid.

Reset
REQ-033 While rst_n=0: msg_ready=0, frame_valid=0, cw_flat=0, range_err=0, cnt=0, state FILL.
REQ-034 After rst_n deasserts, msg_ready SHALL read 1 from the first clock edge.
REQ-035 Reset mid-fill or mid-HOLD SHALL discard the partial or pending frame with no output handshake.

Structure
REQ-036 A shared package SHALL hold AN_A, MSG_W, CW_W, N_ROWS, N_COLS, MSG_MAX=4 and the FSM state enum.
REQ-037 One combinational sub-module, an_encoder_n13, SHALL implement the message-to-codeword multiply; it is the encode-side counterpart of barrett_n13.

Verification
REQ-038 Send 25 messages all 3, frame_ready=1 -> frame_valid one cycle after the 25th acceptance; every slot = 39 (6'b100111); range_err=0.
REQ-039 Send 0,1,2,3,4 repeated five times -> slots k hold 13*(k mod 5) (0,13,26,39,52); a decoder round-trip returns the original messages.
REQ-040 Slot 7 = 5, all other slots 0 -> slot 7 = 1 (65 truncated to 6 bits); range_err=1; range_err is 0 in the next frame.
REQ-041 Send 6 messages of 4, then pulse flush -> slots 0..5 = 52, slots 6..24 = 0; frame_valid asserted next cycle.
REQ-042 Hold frame_ready=0 for 10 cycles in HOLD -> cw_flat stable and msg_ready=0; then frame_ready=1 -> FILL next cycle with the buffer cleared.
REQ-043 Assert rst_n=0 after 12 accepts -> all outputs 0; the next frame starts at slot 0.
